// File: rtl/regfile_pkg.sv
// Shared types and limits for the multi-port register file.
package regfile_pkg;
  typedef enum logic {RF_INIT = 1'b0, RF_RUN = 1'b1} rf_state_e;
  localparam int RF_NUM_RD_MAX = 4;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-entry pending bits: a set marks an issued producer, a write clears it.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              init,
  output logic [DEPTH-1:0]  pend
);

  // Set is evaluated first so it wins over a same-address clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= '0;
    end else if (init) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (set && set_addr == ADDR_W'(i))
          pend[i] <= 1'b1;
        else if (clr && clr_addr == ADDR_W'(i))
          pend[i] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, pending scoreboard and a
// post-reset zeroing sweep so the storage can live in RAM.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rf_raddr,
  output logic [NUM_RD*DATA_W-1:0] rf_rdata,
  output logic [NUM_RD-1:0]        rf_pend,
  input  logic [ADDR_W-1:0]        rf_waddr,
  input  logic [DATA_W-1:0]        rf_wdata,
  input  logic                     rf_we,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  output logic                     init_done
);

  localparam int DEPTH = 2**ADDR_W;

  if (NUM_RD < 1 || NUM_RD > RF_NUM_RD_MAX) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD out of range");
  end

  rf_state_e          state;
  logic [ADDR_W-1:0]  cnt;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]   pend;
  logic               run;
  logic               wr_ok;
  logic               set_ok;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;

  assign run    = (state == RF_RUN);
  assign wr_ok  = run && rf_we && !(ZERO_REG && rf_waddr == '0);
  assign set_ok = run && pend_set && !(ZERO_REG && pend_addr == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RF_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else if (state == RF_INIT) begin
      cnt <= cnt + 1'b1;
      if (&cnt) begin
        state     <= RF_RUN;
        init_done <= 1'b1;
      end
    end
  end

  // Single write port shared between the zeroing sweep and writeback.
  assign mem_we    = !run || wr_ok;
  assign mem_addr  = run ? rf_waddr : cnt;
  assign mem_wdata = run ? rf_wdata : '0;

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_addr] <= mem_wdata;
  end

  regfile_scoreboard #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .set      (set_ok),
    .set_addr (pend_addr),
    .clr      (wr_ok),
    .clr_addr (rf_waddr),
    .init     (!run),
    .pend     (pend)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zero;
    logic              hit;
    assign ra   = rf_raddr[k*ADDR_W +: ADDR_W];
    assign zero = ZERO_REG && ra == '0;
    assign hit  = BYPASS && wr_ok && rf_waddr == ra;
    assign rf_rdata[k*DATA_W +: DATA_W] = (!run || zero) ? '0 :
                                          hit            ? rf_wdata : mem[ra];
    // Forwarded data is final, so the pending flag is masked on a hit.
    assign rf_pend[k] = run && !zero && !hit && pend[ra];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: reference model on the default and no-bypass
// instances, plus directed literal checks and a 4-port/64-bit/8-entry instance.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  raddr;
  logic [63:0] rdata, rdata_nb;
  logic [1:0]  pend, pend_nb;
  logic [4:0]  waddr, pend_addr;
  logic [31:0] wdata;
  logic        we, pend_set, done, done_nb;

  logic [11:0]  p_raddr;
  logic [255:0] p_rdata;
  logic [3:0]   p_pend;
  logic [2:0]   p_waddr, p_paddr;
  logic [63:0]  p_wdata;
  logic         p_we, p_pset, p_done;

  int checks = 0;
  int failures = 0;

  regfile_mp dut (
    .clk(clk), .reset_n(reset_n), .rf_raddr(raddr), .rf_rdata(rdata), .rf_pend(pend),
    .rf_waddr(waddr), .rf_wdata(wdata), .rf_we(we), .pend_set(pend_set),
    .pend_addr(pend_addr), .init_done(done));

  regfile_mp #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .rf_raddr(raddr), .rf_rdata(rdata_nb), .rf_pend(pend_nb),
    .rf_waddr(waddr), .rf_wdata(wdata), .rf_we(we), .pend_set(pend_set),
    .pend_addr(pend_addr), .init_done(done_nb));

  regfile_mp #(.DATA_W(64), .ADDR_W(3), .NUM_RD(4)) dut_p4 (
    .clk(clk), .reset_n(reset_n), .rf_raddr(p_raddr), .rf_rdata(p_rdata), .rf_pend(p_pend),
    .rf_waddr(p_waddr), .rf_wdata(p_wdata), .rf_we(p_we), .pend_set(p_pset),
    .pend_addr(p_paddr), .init_done(p_done));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: contents are zero after any reset, writes and pending
  // updates are ignored until 32 edges have elapsed.
  logic [31:0] m_mem [32];
  bit          m_pend [32];
  int          m_edges;
  bit          m_run;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
      m_edges = 0;
      m_run   = 1'b0;
    end else if (!m_run) begin
      m_edges++;
      if (m_edges == 32) m_run = 1'b1;
    end else begin
      if (we && waddr != 0) begin
        m_mem[waddr]  = wdata;
        m_pend[waddr] = 1'b0;
      end
      if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("init_done", {63'd0, done}, {63'd0, m_run});
    chk("init_done_nb", {63'd0, done_nb}, {63'd0, m_run});
    for (int k = 0; k < 2; k++) begin
      logic [4:0]  a;
      logic        fwd, pst;
      logic [31:0] stored;
      a      = raddr[k*5 +: 5];
      fwd    = m_run && we && waddr != 0 && waddr == a;
      stored = (!m_run || a == 0) ? 32'd0 : m_mem[a];
      pst    = m_run && a != 0 && m_pend[a];
      chk($sformatf("model rdata[%0d]", k), {32'd0, rdata[k*32 +: 32]},
          {32'd0, (fwd ? wdata : stored)});
      chk($sformatf("model pend[%0d]", k), {63'd0, pend[k]}, {63'd0, (fwd ? 1'b0 : pst)});
      chk($sformatf("model nb rdata[%0d]", k), {32'd0, rdata_nb[k*32 +: 32]}, {32'd0, stored});
      chk($sformatf("model nb pend[%0d]", k), {63'd0, pend_nb[k]}, {63'd0, pst});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] pv [4];

  initial begin
    raddr = '0; waddr = '0; wdata = '0; we = 1'b0; pend_set = 1'b0; pend_addr = '0;
    p_raddr = '0; p_waddr = '0; p_wdata = '0; p_we = 1'b0; p_pset = 1'b0; p_paddr = '0;
    pv[0] = 64'h1111_1111_1111_1111; pv[1] = 64'h2222_2222_2222_2222;
    pv[2] = 64'h3333_3333_3333_3333; pv[3] = 64'h4444_4444_4444_4444;
    #2 reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset init_done", {63'd0, done}, 64'd0);
    chk("reset rf_pend", {62'd0, pend}, 64'd0);
    reset_n = 1'b1;

    // Sweep: writes attempted during the first 31 cycles must be dropped.
    we = 1'b1; waddr = 5'd3; wdata = 32'hDEAD_BEEF; raddr = {5'd3, 5'd3};
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 7)  chk("p4 init_done@7", {63'd0, p_done}, 64'd0);
      if (i == 8)  chk("p4 init_done@8", {63'd0, p_done}, 64'd1);
      if (i == 31) begin
        chk("init_done@31", {63'd0, done}, 64'd0);
        we = 1'b0;
      end
      if (i == 32) begin
        chk("init_done@32", {63'd0, done}, 64'd1);
        #1 chk("r3 after sweep", {32'd0, rdata[31:0]}, 64'd0);
      end
    end

    // Write then read on both ports.
    raddr = {5'd1, 5'd1}; we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678;
    tick();
    we = 1'b0; raddr = {5'd5, 5'd5};
    #1 chk("r5 port0", {32'd0, rdata[31:0]}, 64'h1234_5678);
    chk("r5 port1", {32'd0, rdata[63:32]}, 64'h1234_5678);

    // Entry 0 ignores writes, including the bypass path.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr = {5'd0, 5'd0};
    #1 chk("r0 same cycle", {32'd0, rdata[31:0]}, 64'd0);
    tick();
    we = 1'b0;
    #1 chk("r0 after write", {32'd0, rdata[63:32]}, 64'd0);

    // Bypass with a pending entry.
    pend_set = 1'b1; pend_addr = 5'd7;
    tick();
    pend_set = 1'b0; raddr = {5'd7, 5'd0};
    #1 chk("r7 pending", {63'd0, pend[1]}, 64'd1);
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5;
    #1 chk("bypass data", {32'd0, rdata[63:32]}, 64'hA5A5_A5A5);
    chk("bypass pend", {63'd0, pend[1]}, 64'd0);
    chk("no-bypass old data", {32'd0, rdata_nb[63:32]}, 64'd0);
    chk("no-bypass pend", {63'd0, pend_nb[1]}, 64'd1);
    tick();
    we = 1'b0;
    #1 chk("no-bypass new data", {32'd0, rdata_nb[63:32]}, 64'hA5A5_A5A5);
    chk("no-bypass pend cleared", {63'd0, pend_nb[1]}, 64'd0);

    // Scoreboard on r9.
    pend_set = 1'b1; pend_addr = 5'd9; raddr = {5'd0, 5'd9};
    #1 chk("r9 set not same cycle", {63'd0, pend[0]}, 64'd0);
    tick();
    pend_set = 1'b0;
    #1 chk("r9 set visible", {63'd0, pend[0]}, 64'd1);
    we = 1'b1; waddr = 5'd9; wdata = 32'd9;
    #1 chk("r9 nb pend before clear", {63'd0, pend_nb[0]}, 64'd1);
    tick();
    we = 1'b0;
    #1 chk("r9 cleared", {63'd0, pend[0]}, 64'd0);
    pend_set = 1'b1; pend_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'd99;
    tick();
    pend_set = 1'b0; we = 1'b0;
    #1 chk("r9 set wins", {63'd0, pend[0]}, 64'd1);
    chk("r9 data", {32'd0, rdata[31:0]}, 64'd99);

    // Entry 0 is never pending.
    pend_set = 1'b1; pend_addr = 5'd0; raddr = {5'd0, 5'd0};
    tick();
    pend_set = 1'b0;
    #1 chk("r0 never pending", {62'd0, pend}, 64'd0);

    // Four-port instance: distinct entries per port.
    p_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      p_waddr = 3'(k + 1); p_wdata = pv[k];
      tick();
    end
    p_we = 1'b0; p_raddr = {3'd1, 3'd2, 3'd3, 3'd4};
    #1;
    chk("p4 port0", p_rdata[63:0],    64'h4444_4444_4444_4444);
    chk("p4 port1", p_rdata[127:64],  64'h3333_3333_3333_3333);
    chk("p4 port2", p_rdata[191:128], 64'h2222_2222_2222_2222);
    chk("p4 port3", p_rdata[255:192], 64'h1111_1111_1111_1111);

    // Reset mid-operation.
    we = 1'b1; waddr = 5'd4; wdata = 32'h55;
    tick();
    we = 1'b0; pend_set = 1'b1; pend_addr = 5'd4;
    tick();
    pend_set = 1'b0; raddr = {5'd4, 5'd4};
    #1 chk("r4 before reset", {32'd0, rdata[31:0]}, 64'h55);
    chk("r4 pend before reset", {63'd0, pend[0]}, 64'd1);
    reset_n = 1'b0;
    #1 chk("reset pend immediate", {62'd0, pend}, 64'd0);
    chk("reset init_done immediate", {63'd0, done}, 64'd0);
    chk("reset p4 init_done", {63'd0, p_done}, 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    we = 1'b1; waddr = 5'd4; wdata = 32'h77; pend_set = 1'b1; pend_addr = 5'd4;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 31) begin
        chk("re-init_done@31", {63'd0, done}, 64'd0);
        we = 1'b0; pend_set = 1'b0;
      end
      if (i == 32) begin
        chk("re-init_done@32", {63'd0, done}, 64'd1);
        #1 chk("r4 after reset", {32'd0, rdata[31:0]}, 64'd0);
        chk("r4 pend after reset", {63'd0, pend[0]}, 64'd0);
      end
    end
    #1 chk("p4 port3 after reset", p_rdata[255:192], 64'd0);

    we = 1'b1; waddr = 5'd4; wdata = 32'hCAFE_F00D;
    tick();
    we = 1'b0;
    #1 chk("r4 rewrite", {32'd0, rdata[63:32]}, 64'hCAFE_F00D);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the core datapath: configurable width, depth and read-port count, with same-cycle write-to-read bypass and a per-entry pending (scoreboard) bit. After reset an init sweep zeroes the storage one entry per cycle, so the array maps to RAM rather than a reset-per-flop array. It sits between decode (reads, pending checks) and writeback (writes).

## Interface
- `DATA_W`, default 32: entry width in bits.
- `ADDR_W`, default 5: address width; `DEPTH = 2**ADDR_W`.
- `NUM_RD`, default 2: number of read ports, range 1..4.
- `ZERO_REG`, default 1: when 1, entry 0 reads as 0, ignores writes and is never pending.
- `BYPASS`, default 1: when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rf_raddr` in `NUM_RD*ADDR_W`: read addresses; port k uses bits `[k*ADDR_W +: ADDR_W]`.
- `rf_rdata` out `NUM_RD*DATA_W`: read data, combinational, packed the same way.
- `rf_pend` out `NUM_RD`: pending bit for each read address, combinational.
- `rf_waddr` in `ADDR_W`: write address.
- `rf_wdata` in `DATA_W`: write data.
- `rf_we` in 1: write enable. A write also clears the pending bit of `rf_waddr`.
- `pend_set` in 1: mark `pend_addr` pending (a producer has been issued).
- `pend_addr` in `ADDR_W`: address for `pend_set`.
- `init_done` out 1: high once the init sweep is complete.

## Operation
- **States:** `RF_INIT` and `RF_RUN`. Reset forces `RF_INIT`, clears the sweep counter, clears all pending bits and sets `init_done` = 0.
- **`RF_INIT`:**
  - Each cycle writes 0 to entry `cnt`, then increments `cnt`.
  - When the write to entry `DEPTH-1` completes, the state moves to `RF_RUN`.
  - `rf_we` and `pend_set` are ignored.
  - `rf_rdata` is all zeros and `rf_pend` is all zeros.
- **`RF_RUN` write:**
  - Entry `rf_waddr` takes `rf_wdata` on the edge when `rf_we` = 1.
  - The write is suppressed if `ZERO_REG` and `rf_waddr` == 0.
- **`RF_RUN` read:**
  - Port k returns `mem[raddr_k]`.
  - Returns 0 if `ZERO_REG` and `raddr_k` == 0.
  - If `BYPASS`, `rf_we` = 1, `rf_waddr` == `raddr_k` and the write is not suppressed, the port returns `rf_wdata` in the same cycle.
  - Any number of ports may read the same address.
- **Pending bits:**
  - `pend_set` sets `pend[pend_addr]` on the edge.
  - A valid write clears `pend[rf_waddr]` on the edge.
  - If set and clear target the same address in the same cycle, set wins: the bit ends at 1.
  - Pending bits for two different addresses update independently.
- **`rf_pend` output:**
  - `rf_pend[k]` = `pend[raddr_k]`.
  - With `BYPASS`, it is forced to 0 when a valid same-cycle write matches `raddr_k`, because the data is being forwarded.
  - Always 0 for address 0 when `ZERO_REG` = 1.
- **Reset mid-operation:** `reset_n` asserting at any time aborts the current state and restarts the full sweep after release. Contents written before the reset are not preserved.

## Timing
- **Reset values:** `init_done` = 0, all `pend` = 0, `rf_rdata` = 0, `rf_pend` = 0.
- **Init duration:** the sweep takes exactly `DEPTH` cycles. With reset released before edge 1, `init_done` is high after edge `DEPTH` (32 cycles at the default).
- **Read latency:** 0 cycles (combinational). Write to read without bypass is 1 cycle; with `BYPASS` it is 0 cycles.
- **Pending latency:** `pend_set` is visible on `rf_pend` in the cycle after its edge. A write clear is likewise visible the next cycle, or in the same cycle via the bypass mask.
- **Critical path:** no combinational path from `pend_set` to any output.

## Structure
- **Package `regfile_pkg`:** holds the `rf_state_e` enum (`RF_INIT`, `RF_RUN`) and the constant `RF_NUM_RD_MAX` = 4.
- **Sub-module `regfile_scoreboard`:**
  - Contains the `DEPTH`-bit pending vector with asynchronous clear, plus set/clear priority logic.
  - Inputs: `set`, `set_addr`, `clr`, `clr_addr`, `init`.
  - Output: the full pending vector.
- **Top level:** owns the storage array, the sweep FSM, the read muxes and the bypass compare.

## Test plan
- **Init sweep:** release reset, hold `rf_we` = 1 with `rf_waddr` = 3 and `rf_wdata` = `0xDEAD_BEEF` for the first 31 cycles → `init_done` rises after edge 32, and reading address 3 returns `0x0000_0000`.
- **Write then read:** write `0x1234_5678` to r5, then on the next cycle read r5 on both ports → both return `0x1234_5678`. Write `0xFFFF_FFFF` to r0 → reads of r0 return 0.
- **Bypass:** write `0xA5A5_A5A5` to r7 while port 1 reads r7 in the same cycle → `rf_rdata` port 1 = `0xA5A5_A5A5` and `rf_pend[1]` = 0. With `BYPASS` = 0 the port returns the old value.
- **Scoreboard:**
  - `pend_set` on r9 → next cycle `rf_pend` = 1 for a read of r9.
  - Write r9 → pending clears on the following cycle.
  - `pend_set` on r9 together with a write to r9 in the same cycle → pending stays 1.
- **Reset mid-operation:** after r4 = `0x55` and r4 pending, assert `reset_n` low for 1 cycle, then release → `rf_pend` = 0 and `init_done` = 0 immediately, `init_done` returns after 32 cycles, and r4 reads 0.
- **Parametrisation:** `NUM_RD` = 4, `DATA_W` = 64, `ADDR_W` = 3, with four distinct read addresses → each port returns its own entry, and `init_done` rises after 8 cycles.
